// File: rtl/qcm_counter_pkg.sv
// Shared types, default widths and bus helpers for the QCM multi-channel delay counter.
package qcm_counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } chState_e;

  localparam int DEFAULT_COUNTER_SIZE = 16;
  localparam int DEFAULT_HOLD_SIZE    = 2;
  localparam int DEFAULT_DONE_HOLD    = 3;

  // Widest flat delay bus and widest single channel the slicing helper supports.
  localparam int FLAT_MAX  = 512;
  localparam int SLICE_MAX = 32;

  function automatic logic [SLICE_MAX-1:0] sliceDelay(input logic [FLAT_MAX-1:0] flat,
                                                      input int ch,
                                                      input int width);
    logic [SLICE_MAX-1:0] sliceVal;
    logic [SLICE_MAX-1:0] mask;
    sliceVal = SLICE_MAX'(flat >> (ch * width));
    mask     = (width >= SLICE_MAX) ? '1 : ((SLICE_MAX'(1) << width) - SLICE_MAX'(1));
    return sliceVal & mask;
  endfunction

endpackage

// File: rtl/delay_counter_channel.sv
// One delay channel: IDLE/COUNT/DONE FSM with a programmable delay counter and a done-hold counter.
module delay_counter_channel
  import qcm_counter_pkg::*;
#(
  parameter int COUNTER_SIZE = DEFAULT_COUNTER_SIZE,
  parameter int HOLD_SIZE    = DEFAULT_HOLD_SIZE,
  parameter int DONE_HOLD    = DEFAULT_DONE_HOLD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    periodic,
  input  logic [COUNTER_SIZE-1:0] delay,
  output logic                    doneFlag,
  output logic                    busy,
  output logic                    overrun
);

  localparam logic [HOLD_SIZE-1:0] HOLD_LAST = HOLD_SIZE'(DONE_HOLD);

  chState_e              state;
  logic [COUNTER_SIZE-1:0] counter;
  logic [COUNTER_SIZE-1:0] delayLat;
  logic                    periodicLat;
  logic [HOLD_SIZE-1:0]    holdCnt;

  // A zero delay behaves like a one-cycle delay so the channel always passes through COUNT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      counter     <= '0;
      delayLat    <= '0;
      periodicLat <= 1'b0;
      holdCnt     <= '0;
      doneFlag    <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else if (abort) begin
      state    <= IDLE;
      doneFlag <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else if (start) begin
      delayLat    <= (delay == '0) ? COUNTER_SIZE'(1) : delay;
      periodicLat <= periodic;
      counter     <= COUNTER_SIZE'(1);
      state       <= COUNT;
      doneFlag    <= 1'b0;
      busy        <= 1'b1;
      overrun     <= (state != IDLE);
    end else begin
      overrun <= 1'b0;
      case (state)
        COUNT: begin
          if (counter < delayLat) begin
            counter <= counter + COUNTER_SIZE'(1);
          end else begin
            state    <= DONE;
            doneFlag <= 1'b1;
            holdCnt  <= HOLD_SIZE'(1);
          end
        end
        DONE: begin
          if (holdCnt < HOLD_LAST) begin
            holdCnt <= holdCnt + HOLD_SIZE'(1);
          end else begin
            doneFlag <= 1'b0;
            if (periodicLat) begin
              counter <= COUNTER_SIZE'(1);
              state   <= COUNT;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_channel_delay_counter.sv
// NUM_CH independent delay channels; the top only slices the flat buses per channel.
module multi_channel_delay_counter
  import qcm_counter_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int COUNTER_SIZE = DEFAULT_COUNTER_SIZE,
  parameter int DONE_HOLD    = DEFAULT_DONE_HOLD,
  parameter int HOLD_SIZE    = DEFAULT_HOLD_SIZE
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH-1:0]              start,
  input  logic [NUM_CH-1:0]              abort,
  input  logic [NUM_CH-1:0]              periodic,
  input  logic [NUM_CH*COUNTER_SIZE-1:0] delay,
  output logic [NUM_CH-1:0]              doneFlag,
  output logic [NUM_CH-1:0]              busy,
  output logic [NUM_CH-1:0]              overrun
);

  logic [FLAT_MAX-1:0] delayExt;
  assign delayExt = FLAT_MAX'(delay);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [COUNTER_SIZE-1:0] chDelay;
    assign chDelay = COUNTER_SIZE'(sliceDelay(delayExt, i, COUNTER_SIZE));

    delay_counter_channel #(
      .COUNTER_SIZE(COUNTER_SIZE),
      .HOLD_SIZE   (HOLD_SIZE),
      .DONE_HOLD   (DONE_HOLD)
    ) u_channel (
      .clk     (clk),
      .reset   (reset),
      .start   (start[i]),
      .abort   (abort[i]),
      .periodic(periodic[i]),
      .delay   (chDelay),
      .doneFlag(doneFlag[i]),
      .busy    (busy[i]),
      .overrun (overrun[i])
    );
  end

endmodule

// File: doc/multi_channel_delay_counter.md
Name: multi_channel_delay_counter

Overview:
- Parametrised successor of the single-channel done-flag counter on the QCM phase delay board.
- Provides NUM_CH independent delay channels. Each channel has a per-start programmable delay, a configurable done-pulse width, a one-shot or periodic mode, an abort input and retrigger/overrun reporting.
- Sits between the trigger/phase-detect logic and the output pulse drivers. One instance replaces several fixed-count counters.

Parameters:
- NUM_CH, 4, number of independent channels.
- COUNTER_SIZE, 16, bits per channel delay value and counter.
- DONE_HOLD, 3, cycles doneFlag stays high per completion (1..2^HOLD_SIZE-1).
- HOLD_SIZE, 2, bits of the done-hold counter.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  NUM_CH  per-channel start strobe, sampled each edge.
- abort  in  NUM_CH  per-channel abort; returns the channel to idle.
- periodic  in  NUM_CH  mode, latched at start: 1 = periodic, 0 = one-shot.
- delay  in  NUM_CH*COUNTER_SIZE  flat; channel i occupies bits [i*COUNTER_SIZE +: COUNTER_SIZE]; latched at start.
- doneFlag  out  NUM_CH  high for DONE_HOLD cycles when a delay expires.
- busy  out  NUM_CH  high while the channel is in COUNT or DONE.
- overrun  out  NUM_CH  one-cycle pulse when start is accepted while busy.

Behaviour:
- Reset, when high at an edge:
  - all channels go to IDLE;
  - doneFlag = 0, busy = 0, overrun = 0;
  - counters and latched delay/mode = 0.
  - Reset overrides every other input. A mid-count reset drops doneFlag/busy at that same edge.
- Per-channel FSM states: IDLE, COUNT, DONE. Channels are fully independent.
- Priority per channel, per edge: reset > abort > start > normal progress.
- IDLE:
  - start=1 latches delay to D (D=0 is treated as 1) and latches periodic.
  - counter <= 1, state -> COUNT, busy = 1 from the next cycle.
- COUNT:
  - If counter < D, counter increments.
  - If counter == D, state -> DONE, doneFlag = 1, hold counter <= 1.
  - Result: with start sampled at edge k, doneFlag first appears high after edge k+D.
- DONE:
  - doneFlag stays high while hold counter < DONE_HOLD, incrementing the hold counter each edge.
  - At hold counter == DONE_HOLD, doneFlag <= 0.
  - One-shot: state -> IDLE, busy <= 0.
  - Periodic: counter <= 1, state -> COUNT. Period = D + DONE_HOLD cycles.
- Abort in any state: state -> IDLE, doneFlag/busy low after that edge, no overrun. Abort and start in the same cycle: abort wins and start is ignored.
- Start while in COUNT or DONE (retrigger):
  - re-latch delay and mode, counter <= 1, state -> COUNT;
  - doneFlag <= 0;
  - overrun = 1 for exactly one cycle.
- Start held high continuously re-triggers every cycle. doneFlag never asserts, and overrun stays high from the second cycle on.
- Counter arithmetic is unsigned, COUNTER_SIZE bits. The counter never exceeds D, so there is no wrap. D = 2^COUNTER_SIZE-1 must complete correctly.
- Delay-input changes while busy have no effect until the next start.

Decomposition:
- Package qcm_counter_pkg holds:
  - the channel-state enum (IDLE/COUNT/DONE);
  - default width constants (COUNTER_SIZE, HOLD_SIZE, DONE_HOLD);
  - a function to slice channel i out of the flat delay bus.
- Sub-module delay_counter_channel implements one channel's FSM, counter and hold counter. The top generates NUM_CH instances and only slices buses.

Test Plan:
- reset high 2 cycles with start=all ones -> all outputs 0; after release, channel 0 start with delay=5 -> doneFlag[0] high after edge k+5, for exactly 3 cycles, then busy[0]=0.
- delay=0 and delay=1 on channels 1 and 2 started together -> both doneFlags rise after edge k+1, identical waveforms.
- channel 3 periodic=1, delay=4 -> doneFlag[3] high 3 cycles every 7 cycles for ≥4 periods; abort mid-count -> busy[3]=0 next cycle, no further pulses.
- retrigger channel 0 at count 3 of delay=10 with new delay=2 -> overrun[0] one-cycle pulse; doneFlag rises 2 cycles after retrigger; old expiry never appears.
- start and abort together on channel 1 while idle, and while in DONE -> channel ends IDLE, doneFlag low, overrun 0.
- COUNTER_SIZE=4, delay=15 -> doneFlag after exactly 15 cycles, no counter wrap; reset asserted during DONE -> doneFlag low after that edge.
